// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared BCD constants, time struct and digit clamp helper
//               used by the cook timer and keypad entry logic.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    typedef struct packed {
        logic [3:0] min;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } bcd_time_t;

    // Saturate an entered digit to the largest legal value for its position.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] digit,
                                             input logic [3:0] max_val);
        return (digit > max_val) ? max_val : digit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : One-second prescaler; emits a single-cycle tick on wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int unsigned           c_cnt_w    = $clog2(TICKS_PER_SEC);
    localparam logic [c_cnt_w-1:0]    c_tick_max = c_cnt_w'(TICKS_PER_SEC - 1);

    logic [c_cnt_w-1:0] r_count;
    logic               w_wrap;

    assign w_wrap = (r_count == c_tick_max);
    assign tick   = run && w_wrap;

    // Holding while run is low keeps partial seconds across a pause.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (run) begin
            if (w_wrap) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/timer.sv
`default_nettype none
// ============================================================================
// Module      : timer
// Description : Three-digit BCD countdown (M:SS) with expiry flag and pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module timer
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_min,
    input  logic [3:0] load_sec_tens,
    input  logic [3:0] load_sec_ones,
    input  logic       enable,
    output logic [3:0] min,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       zero,
    output logic       done
);

    bcd_time_t r_time;
    bcd_time_t w_dec;
    logic      r_done;
    logic      w_zero;
    logic      w_dec_zero;
    logic      w_run;
    logic      w_clear;
    logic      w_tick;

    assign w_zero  = (r_time == '0);
    assign w_run   = enable && !w_zero;
    assign w_clear = load || w_zero;

    tick_gen #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .run   (w_run),
        .clear (w_clear),
        .tick  (w_tick)
    );

    // Borrow chain; a tick is never issued at 0:00, so min never underflows.
    always_comb begin
        w_dec = r_time;
        if (r_time.sec_ones != 4'd0) begin
            w_dec.sec_ones = r_time.sec_ones - 4'd1;
        end else begin
            w_dec.sec_ones = BCD_MAX;
            if (r_time.sec_tens != 4'd0) begin
                w_dec.sec_tens = r_time.sec_tens - 4'd1;
            end else begin
                w_dec.sec_tens = SEC_TENS_MAX;
                w_dec.min      = r_time.min - 4'd1;
            end
        end
    end

    assign w_dec_zero = (w_dec == '0);

    // Load wins over a coincident tick; the tick is simply dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_time <= '0;
            r_done <= 1'b0;
        end else if (load) begin
            r_time.min      <= bcd_clamp(load_min, BCD_MAX);
            r_time.sec_tens <= bcd_clamp(load_sec_tens, SEC_TENS_MAX);
            r_time.sec_ones <= bcd_clamp(load_sec_ones, BCD_MAX);
            r_done          <= 1'b0;
        end else if (w_tick) begin
            r_time <= w_dec;
            r_done <= w_dec_zero;
        end else begin
            r_done <= 1'b0;
        end
    end

    assign min      = r_time.min;
    assign sec_tens = r_time.sec_tens;
    assign sec_ones = r_time.sec_ones;
    assign zero     = w_zero;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer
// Description : Scoreboard bench for the BCD countdown timer (4 ticks/sec).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] load_min;
    logic [3:0] load_sec_tens;
    logic [3:0] load_sec_ones;
    logic       enable;
    logic [3:0] min;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       zero;
    logic       done;

    timer #(.TICKS_PER_SEC(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .load          (load),
        .load_min      (load_min),
        .load_sec_tens (load_sec_tens),
        .load_sec_ones (load_sec_ones),
        .enable        (enable),
        .min           (min),
        .sec_tens      (sec_tens),
        .sec_ones      (sec_ones),
        .zero          (zero),
        .done          (done)
    );

    typedef struct {
        int         cyc;
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] o;
        logic       z;
        logic       d;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: compare every expectation due at this cycle's falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.cyc != cyc || min !== e.m || sec_tens !== e.t ||
                    sec_ones !== e.o || zero !== e.z || done !== e.d) begin
                    errors++;
                    $display("FAIL %s cyc=%0d(due %0d) got %0d:%0d%0d zero=%0b done=%0b expected %0d:%0d%0d zero=%0b done=%0b",
                             e.name, cyc, e.cyc, min, sec_tens, sec_ones, zero, done,
                             e.m, e.t, e.o, e.z, e.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic push(input int c, input logic [3:0] m, input logic [3:0] t,
                        input logic [3:0] o, input logic z, input logic d,
                        input string n);
        exp_t e;
        e.cyc = c; e.m = m; e.t = t; e.o = o; e.z = z; e.d = d; e.name = n;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns aligned just after the load edge.
    task automatic load_time(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
        load          = 1'b1;
        load_min      = m;
        load_sec_tens = t;
        load_sec_ones = o;
        step(1);
        load          = 1'b0;
    endtask

    initial begin
        int t0;
        int t1;
        rst = 1'b1; load = 1'b0; enable = 1'b0;
        load_min = 4'd0; load_sec_tens = 4'd0; load_sec_ones = 4'd0;

        step(1);
        push(cyc, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, "reset_state");
        step(1);
        rst = 1'b0;
        step(2);

        // 1: 1:00 counts to 0:59 then 0:58
        enable = 1'b1;
        load_time(4'd1, 4'd0, 4'd0);
        t0 = cyc;
        for (int k = 0; k < 9; k++) begin
            if (k < 4)      push(t0 + k, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, "s1_1m00");
            else if (k < 8) push(t0 + k, 4'd0, 4'd5, 4'd9, 1'b0, 1'b0, "s1_0m59");
            else            push(t0 + k, 4'd0, 4'd5, 4'd8, 1'b0, 1'b0, "s1_0m58");
        end
        step(9);

        // 2: 0:01 expires, single done pulse, then holds
        load_time(4'd0, 4'd0, 4'd1);
        t0 = cyc;
        for (int k = 0; k < 25; k++) begin
            if (k < 4)       push(t0 + k, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0, "s2_0m01");
            else if (k == 4) push(t0 + k, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, "s2_expire");
            else             push(t0 + k, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, "s2_hold");
        end
        step(25);

        // 3: clamped load, then loading 0:00 must not raise done
        enable = 1'b0;
        load_time(4'd12, 4'd7, 4'd15);
        push(cyc, 4'd9, 4'd5, 4'd9, 1'b0, 1'b0, "s3_clamp");
        step(2);
        enable = 1'b1;
        load_time(4'd0, 4'd0, 4'd0);
        t0 = cyc;
        for (int k = 0; k < 4; k++)
            push(t0 + k, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, "s3_load_zero");
        step(5);

        // 4: pause keeps the partial second
        load_time(4'd0, 4'd1, 4'd0);
        t0 = cyc;
        for (int k = 0; k < 16; k++) begin
            if (k < 14) push(t0 + k, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0, "s4_paused");
            else        push(t0 + k, 4'd0, 4'd0, 4'd9, 1'b0, 1'b0, "s4_0m09");
        end
        step(2);
        enable = 1'b0;
        step(10);
        enable = 1'b1;
        step(4);

        // 5: load on a tick cycle discards the tick
        load_time(4'd2, 4'd0, 4'd0);
        t0 = cyc;
        for (int k = 0; k < 4; k++)
            push(t0 + k, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, "s5_2m00");
        step(3);
        load_time(4'd0, 4'd3, 4'd0);
        t1 = cyc;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) push(t1 + k, 4'd0, 4'd3, 4'd0, 1'b0, 1'b0, "s5_0m30");
            else       push(t1 + k, 4'd0, 4'd2, 4'd9, 1'b0, 1'b0, "s5_0m29");
        end
        step(6);

        // 6: asynchronous reset mid-count
        load_time(4'd3, 4'd4, 4'd7);
        push(cyc, 4'd3, 4'd4, 4'd7, 1'b0, 1'b0, "s6_3m47");
        step(2);
        #3;
        rst = 1'b1;
        push(cyc, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, "s6_async_rst");
        step(1);
        rst = 1'b0;
        t0 = cyc;
        for (int k = 0; k < 8; k++)
            push(t0 + k, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, "s6_after_rst");
        step(10);

        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer.md
# timer

BCD countdown timer for the microwave datapath. It holds the remaining cook time as three BCD digits: minutes (0-9), seconds-tens (0-5) and seconds-ones (0-9). It decrements the time once per second while enabled and flags expiry. Its digit outputs drive the `min`, `sec_tens` and `sec_ones` inputs of the seven-segment decoder directly; `zero` and `done` go to the control FSM.

## Interface
- `TICKS_PER_SEC`, default 100_000_000: clk cycles per one-second tick. Legal values are ≥ 2; benches use 4.
- `clk` input, 1 bit: system clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `load` input, 1 bit: single-cycle pulse that loads the `load_*` digits.
- `load_min` input, 4 bits: minutes digit to load.
- `load_sec_tens` input, 4 bits: seconds-tens digit to load.
- `load_sec_ones` input, 4 bits: seconds-ones digit to load.
- `enable` input, 1 bit: level input; counting runs while high.
- `min` output, 4 bits: current minutes digit (BCD).
- `sec_tens` output, 4 bits: current seconds-tens digit (BCD).
- `sec_ones` output, 4 bits: current seconds-ones digit (BCD).
- `zero` output, 1 bit: high when the time is 0:00.
- `done` output, 1 bit: one-cycle pulse when a countdown reaches 0:00.

## Operation
- **Reset:** `min`, `sec_tens` and `sec_ones` = 0, prescaler = 0, `done` = 0, so `zero` = 1.
- **Prescaler:**
  - Width is $clog2(TICKS_PER_SEC).
  - It increments each cycle when `enable` is high and `zero` is low.
  - It wraps from TICKS_PER_SEC-1 to 0; the wrap cycle is the tick.
  - It holds its value when `enable` is low; pausing does not lose partial seconds.
  - It clears to 0 on `load`, and stays at 0 while `zero` is high.
- **Decrement on tick:** a borrow chain.
  - If `sec_ones` > 0: decrement `sec_ones`.
  - Else set `sec_ones` to 9 and borrow: if `sec_tens` > 0, decrement `sec_tens`; else set `sec_tens` to 5 and decrement `min`.
  - The borrow never reaches `min` = 0, because `zero` blocks the tick at 0:00.
- **Load:** digits are clamped on entry.
  - `load_min` > 9 loads 9.
  - `load_sec_tens` > 5 loads 5.
  - `load_sec_ones` > 9 loads 9.
  - `load` has priority over a coincident tick. The tick is discarded and the prescaler clears.
- **`zero`:** combinational decode of the digit registers (all digits = 0).
- **`done`:** registered. It is set on the edge where a tick decrement produces 0:00 and clears on the next edge.
  - Loading 0:00 never raises `done`.
  - `done` never re-fires while the timer sits at 0:00.
- **Digit range:** outputs are always valid BCD (`sec_tens` ≤ 5); no illegal state is reachable.

## Timing
- **Load latency:** digits update on the `clk` edge sampling `load`=1, so they are visible 1 cycle after the pulse.
- **First decrement:** occurs on the edge completing TICKS_PER_SEC cycles with `enable`=1 after the load edge. Subsequent decrements are spaced TICKS_PER_SEC enabled cycles apart.
- **Expiry:** `done` and `zero` both rise in the same cycle that the digits first read 0:00. `done` lasts exactly 1 cycle.
- **Mid-operation reset:** `rst` asserted at any time forces the reset values immediately, without waiting for a clock edge. Release is synchronous to the next `clk` edge.
- **`enable` toggling:** `enable` toggling between ticks delays the tick by exactly the number of disabled cycles.

## Structure
- **Shared package:** holds the constants `BCD_MAX` = 4'd9 and `SEC_TENS_MAX` = 4'd5, plus a clamp function. The keypad/entry logic reuses these.
- **Sub-module `tick_gen`:** the prescaler. Inputs `clk`, `rst`, `run`, `clear`; output `tick`. The digit chain and `done` register stay in `timer`.

## Test plan
All scenarios use TICKS_PER_SEC = 4.
1. Load 1:00, hold `enable` → after 4 cycles the digits show 0:59; after 4 more, 0:58. `zero` = 0 and `done` = 0 throughout.
2. Load 0:01, hold `enable` → 4 cycles later the digits show 0:00, `done` = 1 for 1 cycle and `zero` = 1. The digits then hold 0:00 for 20 further cycles with no second `done`.
3. Load `load_min`=12, `load_sec_tens`=7, `load_sec_ones`=15 → the digits read 9:59.
4. Load 0:10, run 2 cycles, drop `enable` for 10 cycles, re-enable → 0:09 appears after exactly 2 more enabled cycles.
5. Load 2:00 running; pulse `load` with 0:30 on a tick cycle → the digits read 0:30 (no 1:59) and the next decrement comes 4 enabled cycles later.
6. Assert `rst` mid-count at 3:47, asynchronously between edges → outputs immediately read 0:00 with `zero` = 1 and `done` = 0. After release with `enable` high, the digits stay at 0.
